i2s_tx: RTL

//   I2S transmitter (Philips format, stereo), clocked from system clk (100 MHz).

---
 rtl/i2s_tx_if.sv | 24 ++
 rtl/i2s_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake bundle between the effects chain and the I2S transmitter.
// The master drives the pair and valid; the slave returns ready.
interface i2s_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// Philips-format stereo I2S transmitter with internal BCLK/LRCLK generation.
// Define I2S_TX_HOLD_LAST_EN to repeat the last pair on underflow instead of silence.
module i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_HALF  = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    i2s_tx_if.slave s,
    output logic    i2s_bclk,
    output logic    i2s_lrclk,
    output logic    i2s_sdata,
    output logic    frame_start,
    output logic    underflow
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BW    = $clog2(FRAME);
    localparam int CW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
    localparam logic [CW-1:0] DIV_TOP  = CW'(BCLK_HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic [FRAME-1:0]      r_shreg;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;

    logic                  w_tick;
    logic                  w_fall;
    logic [BW-1:0]         w_bit_nxt;
    logic                  w_load;
    logic                  w_do_load;
    logic                  w_go_idle;
    logic [DATA_WIDTH-1:0] w_src_l;
    logic [DATA_WIDTH-1:0] w_src_r;
    logic [FRAME-1:0]      w_pat;

    assign w_tick    = (r_div == DIV_TOP);
    assign w_fall    = w_tick & r_bclk;
    assign w_bit_nxt = (r_bit == LAST_BIT) ? '0 : r_bit + BW'(1);
    assign w_load    = w_fall & (w_bit_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_go_idle   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) w_state_nxt = RUN;
            end
            RUN: begin
                w_do_load = w_load;
                if (!en) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    w_state_nxt = RUN;
                    w_do_load   = w_load;
                end else if (w_load) begin
                    w_state_nxt = IDLE;
                    w_go_idle   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef I2S_TX_HOLD_LAST_EN
    logic [DATA_WIDTH-1:0] r_last_l;
    logic [DATA_WIDTH-1:0] r_last_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_do_load && r_hold_full) begin
            r_last_l <= r_hold_l;
            r_last_r <= r_hold_r;
        end
    end

    assign w_src_l = r_hold_full ? r_hold_l : r_last_l;
    assign w_src_r = r_hold_full ? r_hold_r : r_last_r;
`else
    assign w_src_l = r_hold_full ? r_hold_l : '0;
    assign w_src_r = r_hold_full ? r_hold_r : '0;
`endif

    // Each slot: one delay bit, MSB-first sample, zero padding.
    always_comb begin
        w_pat = '0;
        w_pat[FRAME-2 -: DATA_WIDTH]     = w_src_l;
        w_pat[SLOT_BITS-2 -: DATA_WIDTH] = w_src_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_bit   <= LAST_BIT;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b1;
            r_sdata <= 1'b0;
            r_shreg <= '0;
        end else if (r_state != IDLE) begin
            if (w_tick) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + CW'(1);
            end
            if (w_fall) begin
                if (w_go_idle) begin
                    r_bit   <= LAST_BIT;
                    r_lrclk <= 1'b1;
                    r_sdata <= 1'b0;
                end else begin
                    r_bit   <= w_bit_nxt;
                    r_lrclk <= (w_bit_nxt >= BW'(SLOT_BITS));
                    if (w_do_load) begin
                        r_sdata <= w_pat[FRAME-1];
                        r_shreg <= {w_pat[FRAME-2:0], 1'b0};
                    end else begin
                        r_sdata <= r_shreg[FRAME-1];
                        r_shreg <= {r_shreg[FRAME-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else begin
            if (w_do_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
            // An accept in the load clk lands here for the following frame.
            if (s.s_valid && !r_hold_full) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= s.s_left;
                r_hold_r    <= s.s_right;
            end
        end
    end

    assign s.s_ready   = ~r_hold_full;
    assign i2s_bclk    = r_bclk;
    assign i2s_lrclk   = r_lrclk;
    assign i2s_sdata   = r_sdata;
    assign frame_start = w_do_load;
    assign underflow   = w_do_load & ~r_hold_full;
endmodule
